adder_reduction_ctrl: RTL

ADDER_REDUCTION_CTRL -- requirements
Module: adder_reduction_ctrl

---
 rtl/adder_reduction_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/adder_reduction_ctrl.sv
// Controller that loads num_terms unsigned words into a local buffer and
// sums them as a pairwise tree, driving an external registered adder array
// (array_size lanes, one-cycle latency). The result is presented with a
// valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on state, never on in_valid. out_valid and out_sum
// stay stable until out_ready accepts them.
module adder_reduction_ctrl #(
    parameter int data_width = 18,
    parameter int array_size = 2,
    parameter int num_terms  = 8,
    localparam int acc_width = data_width + $clog2(num_terms)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [data_width-1:0]               in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [acc_width-1:0]                out_sum,
    output logic                                arr_enable,
    output logic [acc_width*array_size-1:0]     arr_num_1,
    output logic [acc_width*array_size-1:0]     arr_num_2,
    input  logic [(acc_width+1)*array_size-1:0] arr_out_num,
    output logic                                busy,
    output logic [1:0]                          dbg_state
);

    localparam int idx_w = $clog2(num_terms);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [idx_w-1:0]     idx_q;
    logic [idx_w-1:0]     pass_q;
    logic [idx_w-1:0]     group_q;
    logic [acc_width-1:0] buf_q [num_terms];

    int                   pairs;
    logic                 last_group;
    logic                 lane_act  [array_size];
    logic [idx_w-1:0]     lane_dst  [array_size];
    logic [idx_w-1:0]     lane_rd_a [array_size];
    logic [idx_w-1:0]     lane_rd_b [array_size];
    logic                 unused_carry;

    // Map lanes of the current group onto pair indices of the current pass.
    // Inactive lanes may compute aliased indices; they are gated by lane_act.
    always_comb begin
        pairs      = num_terms >> (int'(pass_q) + 1);
        last_group = ((int'(group_q) + 1) * array_size) >= pairs;
        for (int k = 0; k < array_size; k++) begin
            lane_act[k]  = (int'(group_q) * array_size + k) < pairs;
            lane_dst[k]  = idx_w'(int'(group_q) * array_size + k);
            lane_rd_a[k] = idx_w'(2 * (int'(group_q) * array_size + k));
            lane_rd_b[k] = idx_w'(2 * (int'(group_q) * array_size + k) + 1);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_sum    = '0;
        arr_enable = 1'b0;
        arr_num_1  = '0;
        arr_num_2  = '0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx_q == idx_w'(num_terms - 1)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                arr_enable = 1'b1;
                for (int k = 0; k < array_size; k++) begin
                    if (lane_act[k]) begin
                        arr_num_1[k*acc_width +: acc_width] = buf_q[lane_rd_a[k]];
                        arr_num_2[k*acc_width +: acc_width] = buf_q[lane_rd_b[k]];
                    end
                end
                state_d = WAIT;
            end
            WAIT: begin
                state_d = (last_group && pairs == 1) ? DONE : ISSUE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = buf_q[0];
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer writes (loads and lane results) plus index/pass/group counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            pass_q  <= '0;
            group_q <= '0;
            for (int i = 0; i < num_terms; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        buf_q[idx_q] <= acc_width'(in_data);
                        if (idx_q == idx_w'(num_terms - 1)) begin
                            idx_q   <= '0;
                            pass_q  <= '0;
                            group_q <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Results land at index j, below every slot a later group
                    // of this pass still has to read.
                    for (int k = 0; k < array_size; k++) begin
                        if (lane_act[k]) begin
                            buf_q[lane_dst[k]] <= arr_out_num[k*(acc_width+1) +: acc_width];
                        end
                    end
                    if (!last_group) begin
                        group_q <= group_q + 1'b1;
                    end else if (pairs > 1) begin
                        pass_q  <= pass_q + 1'b1;
                        group_q <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        idx_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane carry bits can never be set because acc_width already covers the full sum.
    assign unused_carry = ^arr_out_num;
    assign busy         = (state_q != LOAD);
    assign dbg_state    = state_q;

endmodule
